// File: rtl/dds_pkg.sv
// Shared constants and types for the multi-channel DDS tuning-word controller.
// Scale factors assume a 50 MHz system clock.
package dds_pkg;

    localparam int FRE_K_DEF     = 5629500;
    localparam int FRE_SHIFT_DEF = 16;
    localparam int PHA_K_DEF     = 2913;
    localparam int PHA_SHIFT_DEF = 8;
    localparam int PHA_MAX_DEG   = 359;

    typedef enum logic {
        OP_BASE  = 1'b0,
        OP_DELTA = 1'b1
    } cfg_op_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        WRITE
    } state_t;

endpackage

// File: rtl/dds_serial_mult.sv
// MSB-first shift-add multiplier by a constant: one multiplier bit per step,
// result valid on the cycle done is high.
module dds_serial_mult #(
    parameter int A_W = 27,
    parameter int K   = 5629500,
    parameter int K_W = 23
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               step,
    input  logic               last,
    input  logic [A_W-1:0]     a,
    output logic               done,
    output logic [A_W+K_W-1:0] product
);

    localparam int P_W = A_W + K_W;
    localparam logic [P_W-1:0] K_EXT = P_W'(K);

    logic [A_W-1:0] a_sh;

    // Each step doubles the partial sum and adds K when the current top bit is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh    <= '0;
            product <= '0;
            done    <= 1'b0;
        end else if (start) begin
            a_sh    <= a;
            product <= '0;
            done    <= 1'b0;
        end else if (step) begin
            product <= {product[P_W-2:0], 1'b0} + (a_sh[A_W-1] ? K_EXT : '0);
            a_sh    <= {a_sh[A_W-2:0], 1'b0};
            done    <= last;
        end else begin
            done    <= 1'b0;
        end
    end

endmodule

// File: rtl/dds_tune_ctrl.sv
// Multi-channel frequency/phase word controller with a shared serial multiplier,
// double-buffered outputs and a linear frequency sweep.
module dds_tune_ctrl
    import dds_pkg::*;
#(
    parameter int CH        = 2,
    parameter int N         = 32,
    parameter int M         = 12,
    parameter int FRE_WIDTH = 27,
    parameter int PHA_WIDTH = 9,
    parameter int FRE_K     = FRE_K_DEF,
    parameter int FRE_SHIFT = FRE_SHIFT_DEF,
    parameter int PHA_K     = PHA_K_DEF,
    parameter int PHA_SHIFT = PHA_SHIFT_DEF,
    parameter int SWEEP_DIV = 1000,
    localparam int CH_W     = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic                 cfg_op,
    input  logic [FRE_WIDTH-1:0] cfg_fre,
    input  logic [PHA_WIDTH-1:0] cfg_pha,
    input  logic                 update,
    input  logic                 sweep_en,
    output logic [CH*N-1:0]      fre_step,
    output logic [CH*M-1:0]      pha_step
);

    localparam int FRE_K_W = $clog2(FRE_K + 1);
    localparam int PHA_K_W = $clog2(PHA_K + 1);
    localparam int CNT_W   = $clog2(FRE_WIDTH);
    localparam int SW_W    = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;

    state_t                         state, next_state;
    logic                           start, step, last, ch_ok;
    logic [CNT_W-1:0]               bit_cnt;
    logic [CH_W-1:0]                ch_q;
    cfg_op_t                        op_q;
    logic [PHA_WIDTH-1:0]           pha_sat;
    logic                           fre_done, pha_done, wr_fre, wr_pha;
    logic [FRE_WIDTH+FRE_K_W-1:0]   fre_prod;
    logic [FRE_WIDTH+PHA_K_W-1:0]   pha_prod;
    logic [N-1:0]                   fre_res;
    logic [M-1:0]                   pha_res;
    logic [N-1:0]                   shadow_fre [CH];
    logic [M-1:0]                   shadow_pha [CH];
    logic [N-1:0]                   delta      [CH];
    logic [SW_W-1:0]                sweep_cnt;
    logic                           sweep_tick;

    assign ch_ok   = (int'(cfg_ch) < CH);
    assign pha_sat = (cfg_pha > PHA_WIDTH'(PHA_MAX_DEG)) ? PHA_WIDTH'(PHA_MAX_DEG) : cfg_pha;
    assign last    = (bit_cnt == CNT_W'(FRE_WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Out-of-range channels are accepted but never start the multiplier.
    always_comb begin
        next_state = state;
        cfg_ready  = 1'b0;
        start      = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid && ch_ok) begin
                    start      = 1'b1;
                    next_state = MUL;
                end
            end
            MUL: begin
                step = 1'b1;
                if (last) next_state = WRITE;
            end
            WRITE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_q    <= '0;
            op_q    <= OP_BASE;
            bit_cnt <= '0;
        end else if (start) begin
            ch_q    <= cfg_ch;
            op_q    <= cfg_op_t'(cfg_op);
            bit_cnt <= '0;
        end else if (step) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    dds_serial_mult #(.A_W(FRE_WIDTH), .K(FRE_K), .K_W(FRE_K_W)) u_fre_mult (
        .clk(clk), .rst(rst), .start(start), .step(step), .last(last),
        .a(cfg_fre), .done(fre_done), .product(fre_prod)
    );

    // Phase rides on the frequency bit counter, so it is widened to FRE_WIDTH.
    dds_serial_mult #(.A_W(FRE_WIDTH), .K(PHA_K), .K_W(PHA_K_W)) u_pha_mult (
        .clk(clk), .rst(rst), .start(start), .step(step), .last(last),
        .a(FRE_WIDTH'(pha_sat)), .done(pha_done), .product(pha_prod)
    );

    assign fre_res = N'(fre_prod >> FRE_SHIFT);
    assign pha_res = M'(pha_prod >> PHA_SHIFT);
    assign wr_fre  = (state == WRITE) && fre_done;
    assign wr_pha  = (state == WRITE) && pha_done && (op_q == OP_BASE);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                shadow_fre[c] <= '0;
                shadow_pha[c] <= '0;
                delta[c]      <= '0;
            end
        end else begin
            if (wr_fre && op_q == OP_BASE)  shadow_fre[ch_q] <= fre_res;
            if (wr_fre && op_q == OP_DELTA) delta[ch_q]      <= fre_res;
            if (wr_pha)                     shadow_pha[ch_q] <= pha_res;
        end
    end

    assign sweep_tick = sweep_en && (sweep_cnt == SW_W'(SWEEP_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || !sweep_en || sweep_tick) sweep_cnt <= '0;
        else                                sweep_cnt <= sweep_cnt + SW_W'(1);
    end

    // An update takes priority over a coincident sweep increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            fre_step <= '0;
            pha_step <= '0;
        end else if (update) begin
            for (int c = 0; c < CH; c++) begin
                fre_step[c*N +: N] <= shadow_fre[c];
                pha_step[c*M +: M] <= shadow_pha[c];
            end
        end else if (sweep_tick) begin
            for (int c = 0; c < CH; c++)
                fre_step[c*N +: N] <= fre_step[c*N +: N] + delta[c];
        end
    end

endmodule

// File: tb/tb_dds_tune_ctrl.sv
// Self-checking bench for dds_tune_ctrl against an arithmetic, cycle-timed
// reference model of shadow/active registers and the sweep schedule.
module tb_dds_tune_ctrl;

    localparam int CH        = 3;
    localparam int CH_W      = 2;
    localparam int N         = 32;
    localparam int M         = 12;
    localparam int FW        = 27;
    localparam int PW        = 9;
    localparam int SWEEP_DIV = 4;
    localparam longint unsigned FRE_K = 5629500;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [CH_W-1:0] cfg_ch = '0;
    logic            cfg_op = 1'b0;
    logic [FW-1:0]   cfg_fre = '0;
    logic [PW-1:0]   cfg_pha = '0;
    logic            update = 1'b0;
    logic            sweep_en = 1'b0;
    logic [CH*N-1:0] fre_step;
    logic [CH*M-1:0] pha_step;

    dds_tune_ctrl #(
        .CH(CH), .N(N), .M(M), .FRE_WIDTH(FW), .PHA_WIDTH(PW), .SWEEP_DIV(SWEEP_DIV)
    ) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_op(cfg_op), .cfg_fre(cfg_fre), .cfg_pha(cfg_pha),
        .update(update), .sweep_en(sweep_en), .fre_step(fre_step), .pha_step(pha_step)
    );

    always #5 clk = ~clk;

    logic [N-1:0]  m_act_fre [CH];
    logic [N-1:0]  m_sh_fre  [CH];
    logic [N-1:0]  m_delta   [CH];
    logic [M-1:0]  m_act_pha [CH];
    logic [M-1:0]  m_sh_pha  [CH];
    bit            m_pend;
    int            m_due, m_ch, m_sweep_cnt, edge_no;
    bit            m_op;
    logic [FW-1:0] m_fre;
    logic [PW-1:0] m_pha;
    int            n_checks = 0;
    int            n_fail = 0;

    function automatic logic [N-1:0] exp_fre(input logic [63:0] f);
        return N'((f * FRE_K) >> 16);
    endfunction

    function automatic logic [M-1:0] exp_pha(input int p);
        int q;
        q = (p > 359) ? 359 : p;
        return M'((q * 2913) >> 8);
    endfunction

    function automatic logic [CH*N-1:0] pack_fre();
        logic [CH*N-1:0] r;
        for (int c = 0; c < CH; c++) r[c*N +: N] = m_act_fre[c];
        return r;
    endfunction

    function automatic logic [CH*M-1:0] pack_pha();
        logic [CH*M-1:0] r;
        for (int c = 0; c < CH; c++) r[c*M +: M] = m_act_pha[c];
        return r;
    endfunction

    // Advance the model by one clock edge using the current inputs, then the DUT.
    task automatic step();
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                m_act_fre[c] = '0; m_sh_fre[c] = '0; m_delta[c] = '0;
                m_act_pha[c] = '0; m_sh_pha[c] = '0;
            end
            m_pend = 0;
            m_sweep_cnt = 0;
        end else begin
            if (update) begin
                for (int c = 0; c < CH; c++) begin
                    m_act_fre[c] = m_sh_fre[c];
                    m_act_pha[c] = m_sh_pha[c];
                end
            end else if (sweep_en && m_sweep_cnt == SWEEP_DIV - 1) begin
                for (int c = 0; c < CH; c++) m_act_fre[c] = m_act_fre[c] + m_delta[c];
            end
            m_sweep_cnt = sweep_en ? (m_sweep_cnt + 1) % SWEEP_DIV : 0;
            if (m_pend) begin
                if (edge_no + 1 == m_due) begin
                    if (!m_op) begin
                        m_sh_fre[m_ch] = exp_fre(64'(m_fre));
                        m_sh_pha[m_ch] = exp_pha(int'(m_pha));
                    end else begin
                        m_delta[m_ch] = exp_fre(64'(m_fre));
                    end
                    m_pend = 0;
                end
            end else if (cfg_valid && int'(cfg_ch) < CH) begin
                m_pend = 1;
                m_due  = edge_no + 1 + FW + 1;
                m_ch   = int'(cfg_ch);
                m_op   = cfg_op;
                m_fre  = cfg_fre;
                m_pha  = cfg_pha;
            end
        end
        @(posedge clk);
        edge_no++;
        #1;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (m_pend && guard < 100) begin
            step();
            guard++;
        end
        if (m_pend) begin
            n_checks++; n_fail++;
            $display("[TB] FAIL cfg_timeout: request still pending after %0d cycles, required done", guard);
        end
    endtask

    task automatic do_cfg(input int ch, input bit op, input int fre, input int pha);
        cfg_ch = CH_W'(ch); cfg_op = op; cfg_fre = FW'(fre); cfg_pha = PW'(pha);
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        wait_idle();
    endtask

    task automatic do_update();
        update = 1'b1;
        step();
        update = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b, required 1", cfg_ready); end
        n_checks++; if (fre_step !== '0) begin n_fail++; $display("[TB] FAIL reset_fre: got %h, required 0", fre_step); end
        n_checks++; if (pha_step !== '0) begin n_fail++; $display("[TB] FAIL reset_pha: got %h, required 0", pha_step); end
    endtask

    task automatic test_base_ch0();
        cfg_ch = 0; cfg_op = 0; cfg_fre = FW'(1000); cfg_pha = PW'(90);
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        for (int k = 1; k <= FW + 2; k++) begin
            n_checks++;
            if (cfg_ready !== (k == FW + 2)) begin
                n_fail++;
                $display("[TB] FAIL busy_window cycle %0d: got %b, required %b", k, cfg_ready, (k == FW + 2));
            end
            if (k < FW + 2) step();
        end
        n_checks++; if (fre_step !== '0) begin n_fail++; $display("[TB] FAIL shadow_isolated: got %h, required 0", fre_step); end
        do_update();
        n_checks++; if (fre_step[0 +: N] !== 32'd85899) begin n_fail++; $display("[TB] FAIL ch0_fre: got %0d, required 85899", fre_step[0 +: N]); end
        n_checks++; if (pha_step[0 +: M] !== 12'd1024) begin n_fail++; $display("[TB] FAIL ch0_pha: got %0d, required 1024", pha_step[0 +: M]); end
        n_checks++; if (fre_step[N +: N] !== '0) begin n_fail++; $display("[TB] FAIL ch1_untouched: got %0d, required 0", fre_step[N +: N]); end
    endtask

    task automatic test_base_ch1();
        do_cfg(1, 0, 1000000, 180);
        do_update();
        n_checks++; if (fre_step[N +: N] !== 32'd85899353) begin n_fail++; $display("[TB] FAIL ch1_fre: got %0d, required 85899353", fre_step[N +: N]); end
        n_checks++; if (pha_step[M +: M] !== 12'd2048) begin n_fail++; $display("[TB] FAIL ch1_pha: got %0d, required 2048", pha_step[M +: M]); end
        do_cfg(1, 0, 1000000, 400);
        do_update();
        n_checks++; if (pha_step[M +: M] !== 12'd4085) begin n_fail++; $display("[TB] FAIL pha_saturate: got %0d, required 4085", pha_step[M +: M]); end
        n_checks++; if (pha_step !== pack_pha()) begin n_fail++; $display("[TB] FAIL pha_model: got %h, required %h", pha_step, pack_pha()); end
    endtask

    task automatic test_sweep();
        do_cfg(0, 0, 1000, 90);
        do_cfg(0, 1, 1000, 0);
        do_update();
        sweep_en = 1'b1;
        repeat (4) step();
        n_checks++; if (fre_step[0 +: N] !== 32'd171798) begin n_fail++; $display("[TB] FAIL sweep_first_tick: got %0d, required 171798", fre_step[0 +: N]); end
        for (int k = 0; k < 12; k++) begin
            step();
            n_checks++; if (fre_step !== pack_fre()) begin n_fail++; $display("[TB] FAIL sweep_cycle %0d: got %h, required %h", k, fre_step, pack_fre()); end
        end
        n_checks++; if (pha_step !== pack_pha()) begin n_fail++; $display("[TB] FAIL sweep_pha_static: got %h, required %h", pha_step, pack_pha()); end
        sweep_en = 1'b0;
        step();
    endtask

    task automatic test_sweep_wrap();
        do_cfg(2, 0, 49999995, 10);
        do_cfg(2, 1, 1000, 0);
        do_update();
        n_checks++; if (fre_step[2*N +: N] !== 32'hFFFFFFB5) begin n_fail++; $display("[TB] FAIL wrap_base: got %h, required ffffffb5", fre_step[2*N +: N]); end
        sweep_en = 1'b1;
        repeat (4) step();
        n_checks++; if (fre_step[2*N +: N] !== 32'd85824) begin n_fail++; $display("[TB] FAIL wrap_result: got %0d, required 85824", fre_step[2*N +: N]); end
        for (int k = 0; k < 6; k++) begin
            step();
            n_checks++; if (fre_step !== pack_fre()) begin n_fail++; $display("[TB] FAIL wrap_cycle %0d: got %h, required %h", k, fre_step, pack_fre()); end
        end
    endtask

    task automatic test_update_tick();
        int guard = 0;
        while (m_sweep_cnt != SWEEP_DIV - 1 && guard < 10) begin step(); guard++; end
        update = 1'b1;
        step();
        update = 1'b0;
        n_checks++; if (fre_step[0 +: N] !== 32'd85899) begin n_fail++; $display("[TB] FAIL update_beats_tick: got %0d, required 85899", fre_step[0 +: N]); end
        n_checks++; if (fre_step !== pack_fre()) begin n_fail++; $display("[TB] FAIL update_tick_model: got %h, required %h", fre_step, pack_fre()); end
        sweep_en = 1'b0;
        step();
    endtask

    task automatic test_update_write();
        int guard = 0;
        cfg_ch = 1; cfg_op = 0; cfg_fre = FW'(2000); cfg_pha = PW'(45);
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        while (edge_no + 1 != m_due && guard < 100) begin step(); guard++; end
        do_update();
        n_checks++; if (fre_step[N +: N] !== 32'd85899353) begin n_fail++; $display("[TB] FAIL update_pre_write: got %0d, required 85899353", fre_step[N +: N]); end
        do_update();
        n_checks++; if (fre_step[N +: N] !== exp_fre(64'd2000)) begin n_fail++; $display("[TB] FAIL update_post_write: got %0d, required %0d", fre_step[N +: N], exp_fre(64'd2000)); end
        n_checks++; if (pha_step !== pack_pha()) begin n_fail++; $display("[TB] FAIL update_write_pha: got %h, required %h", pha_step, pack_pha()); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            do_cfg(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, (1 << FW) - 1)), int'($urandom_range(0, 511)));
            if ($urandom_range(0, 2) != 0) do_update();
            else step();
            n_checks++; if (fre_step !== pack_fre()) begin n_fail++; $display("[TB] FAIL random_fre %0d: got %h, required %h", i, fre_step, pack_fre()); end
            n_checks++; if (pha_step !== pack_pha()) begin n_fail++; $display("[TB] FAIL random_pha %0d: got %h, required %h", i, pha_step, pack_pha()); end
        end
    endtask

    task automatic test_back_to_back();
        logic [CH*N-1:0] fre_before;
        logic [CH*M-1:0] pha_before;
        int acc = -1;
        cfg_ch = 0; cfg_op = 0; cfg_fre = FW'(3000); cfg_pha = PW'(30);
        cfg_valid = 1'b1;
        step();
        cfg_ch = 2; cfg_fre = FW'(7000); cfg_pha = PW'(270);
        for (int k = 1; k <= 40; k++) begin
            if (cfg_ready) begin
                acc = k;
                step();
                break;
            end
            step();
        end
        cfg_valid = 1'b0;
        n_checks++; if (acc != FW + 2) begin n_fail++; $display("[TB] FAIL b2b_accept_cycle: got %0d, required %0d", acc, FW + 2); end
        wait_idle();
        do_update();
        n_checks++; if (fre_step !== pack_fre()) begin n_fail++; $display("[TB] FAIL b2b_fre: got %h, required %h", fre_step, pack_fre()); end
        n_checks++; if (pha_step[2*M +: M] !== exp_pha(270)) begin n_fail++; $display("[TB] FAIL b2b_pha: got %0d, required %0d", pha_step[2*M +: M], exp_pha(270)); end
        fre_before = fre_step;
        pha_before = pha_step;
        cfg_ch = 3; cfg_op = 0; cfg_fre = FW'(12345); cfg_pha = PW'(12);
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL discard_ready: got %b, required 1", cfg_ready); end
        repeat (FW + 4) step();
        do_update();
        n_checks++; if (fre_step !== fre_before) begin n_fail++; $display("[TB] FAIL discard_fre: got %h, required %h", fre_step, fre_before); end
        n_checks++; if (pha_step !== pha_before) begin n_fail++; $display("[TB] FAIL discard_pha: got %h, required %h", pha_step, pha_before); end
    endtask

    task automatic test_reset_mid_mul();
        cfg_ch = 1; cfg_op = 0; cfg_fre = FW'(12345); cfg_pha = PW'(30);
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (fre_step !== '0) begin n_fail++; $display("[TB] FAIL midmul_fre: got %h, required 0", fre_step); end
        n_checks++; if (pha_step !== '0) begin n_fail++; $display("[TB] FAIL midmul_pha: got %h, required 0", pha_step); end
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midmul_ready: got %b, required 1", cfg_ready); end
        repeat (FW + 4) step();
        do_update();
        n_checks++; if (fre_step !== '0) begin n_fail++; $display("[TB] FAIL midmul_no_write: got %h, required 0", fre_step); end
    endtask

    initial begin
        edge_no = 0;
        test_reset();
        test_base_ch0();
        test_base_ch1();
        test_sweep();
        test_sweep_wrap();
        test_update_tick();
        test_update_write();
        test_random();
        test_back_to_back();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
